game_timer: RTL and testbench
=============================

# game_timer

Parametrised game-clock block generating sub-second and one-second strobes from the system clock, with a loadable seconds counter that counts up or down and flags expiry. It drives the round timer, blink and animation cadence, and time-out detection in the fishing game. It generalises the fixed 100 MHz half-second/one-second enable generator to any clock rate, any number of sub-ticks per second, and any seconds width.

## Interface
- CLK_HZ, 100000000, clock cycles per second; must be divisible by SUBDIV
- SUBDIV, 2, sub-ticks per second (≥1); STEP = CLK_HZ/SUBDIV
- SEC_W, 8, width of seconds counter; MAX = 2^SEC_W−1
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  game-active; 0 clears prescaler and suppresses ticks
- pause  in  1  freeze prescaler, no ticks, seconds held
- load  in  1  one-cycle load strobe
- load_sec  in  SEC_W  value loaded into seconds on load
- down  in  1  count direction: 1 = down to 0, 0 = up to MAX
- sub_tick  out  1  one-cycle pulse every STEP enabled cycles
- sec_tick  out  1  one-cycle pulse every CLK_HZ enabled cycles, coincident with a sub_tick
- seconds  out  SEC_W  current seconds count
- expired  out  1  level; limit reached (0 when down, MAX when up)
- expire_pulse  out  1  one-cycle pulse on the edge expired rises

## Operation
- Prescaler pre: width $clog2(CLK_HZ), range 0..CLK_HZ−1, wraps to 0.
- Enabled cycle: run=1 & pause=0 & expired=0 & load=0.
- Priority per edge: rst > load > run=0 > pause/expired > count.
- load: seconds←load_sec, pre←0, expired←0, expire_pulse←0, no tick pulses that cycle; load is honoured even when run=0 or pause=1.
- run=0 (no load): pre←0; seconds and expired held; pulses 0.
- pause=1 or expired=1: pre and seconds held; pulses 0.
- Enabled: pre←pre+1 (or 0 at CLK_HZ−1). sub_tick←1 when pre ∈ {STEP−1, 2·STEP−1, …, CLK_HZ−1}; sec_tick←1 when pre = CLK_HZ−1; else both ←0.
- On the sec_tick edge, seconds updates on the same edge: down: seconds−1; up: seconds+1. If the new value equals the limit (0 down, MAX up), expired←1 and expire_pulse←1 on that edge.
- A loaded value already at the limit does not set expired; one full second elapses and then the counter wraps (down: 0→MAX, up: MAX→0) without expiring. Subsequent counting then expires normally on reaching the limit.
- Changing down while counting takes effect at the next sec_tick; expired is cleared only by load or rst.

## Timing
- Reset values: pre=0, seconds=0, expired=0, sub_tick=0, sec_tick=0, expire_pulse=0.
- All outputs registered; no combinational input→output path.
- The k-th enabled edge counted from pre=0 (pre 0→1 is edge 1) with k a multiple of STEP raises sub_tick for exactly the one following cycle. When k is a multiple of CLK_HZ it also raises sec_tick, and seconds updates on that same edge.
- Pause of P cycles delays all later ticks by exactly P cycles; no tick is lost or duplicated.
- Load in the same cycle as a prescaler wrap: load wins, no sec_tick, seconds = load_sec.
- Reset mid-second: all state returns to reset values immediately (asynchronous); counting restarts from pre=0 after rst falls.

## Test plan
Bench parameters: CLK_HZ=12, SUBDIV=3, SEC_W=4 (STEP=4, MAX=15).
- Reset with run=1 -> all outputs 0 while rst high; after release, sub_tick high after enabled edges 4, 8, 12. sec_tick is high only after edge 12, and seconds then reads 1 (up mode). After edge 24, seconds reads 2.
- Run up, pause for 5 cycles after edge 6 -> sub_ticks after edges 8, 12 appear 5 cycles late; seconds=1 after 17 total cycles from start.
- load=1, load_sec=3, down=1, then run -> seconds 2, 1, 0 after 12, 24, 36 enabled edges. expired rises with seconds=0 and expire_pulse is high one cycle; no further ticks for 30 cycles. A subsequent load of 2 clears expired and counting resumes.
- Up mode, load 14 -> seconds 15 after 12 cycles with expired=1 and expire_pulse once; seconds holds 15 thereafter.
- load asserted on the cycle pre=11 with load_sec=7 -> no sec_tick; seconds=7, pre=0. The next sec_tick follows 12 enabled cycles later.
- run dropped at pre=9 for 3 cycles then re-asserted -> pre restarts at 0; next sec_tick 12 enabled cycles after re-assertion; seconds unchanged while run=0.

Source files
------------

// File: rtl/game_timer.sv
// Game clock: prescaler producing sub-second and one-second strobes, plus a
// loadable up/down seconds counter that flags and pulses on reaching its limit.
module game_timer #(
  parameter int CLK_HZ = 100000000,
  parameter int SUBDIV = 2,
  parameter int SEC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             pause,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             down,
  output logic             sub_tick,
  output logic             sec_tick,
  output logic [SEC_W-1:0] seconds,
  output logic             expired,
  output logic             expire_pulse
);
  localparam int STEP  = CLK_HZ / SUBDIV;
  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SUB_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  // Phase within the current sub-tick; always equals pre mod STEP, which
  // avoids a divider on the prescaler.
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [SEC_W-1:0] seconds_q, seconds_d, sec_next, sec_limit;
  logic             expired_q, expired_d;
  logic             sub_tick_q, sub_tick_d;
  logic             sec_tick_q, sec_tick_d;
  logic             expire_pulse_q, expire_pulse_d;

  always_comb begin
    pre_d          = pre_q;
    sub_d          = sub_q;
    seconds_d      = seconds_q;
    expired_d      = expired_q;
    sub_tick_d     = 1'b0;
    sec_tick_d     = 1'b0;
    expire_pulse_d = 1'b0;
    sec_next       = down ? (seconds_q - 1'b1) : (seconds_q + 1'b1);
    sec_limit      = down ? '0 : '1;

    if (load) begin
      seconds_d = load_sec;
      pre_d     = '0;
      sub_d     = '0;
      expired_d = 1'b0;
    end else if (!run) begin
      pre_d = '0;
      sub_d = '0;
    end else if (!pause && !expired_q) begin
      pre_d      = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      sub_d      = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
      sub_tick_d = (sub_q == SUB_LAST);
      if (pre_q == PRE_LAST) begin
        sec_tick_d = 1'b1;
        seconds_d  = sec_next;
        // Only a count that arrives at the limit expires; a loaded limit
        // value simply wraps on its first second.
        if (sec_next == sec_limit) begin
          expired_d      = 1'b1;
          expire_pulse_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q          <= '0;
      sub_q          <= '0;
      seconds_q      <= '0;
      expired_q      <= 1'b0;
      sub_tick_q     <= 1'b0;
      sec_tick_q     <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      sub_q          <= sub_d;
      seconds_q      <= seconds_d;
      expired_q      <= expired_d;
      sub_tick_q     <= sub_tick_d;
      sec_tick_q     <= sec_tick_d;
      expire_pulse_q <= expire_pulse_d;
    end
  end

  assign sub_tick     = sub_tick_q;
  assign sec_tick     = sec_tick_q;
  assign seconds      = seconds_q;
  assign expired      = expired_q;
  assign expire_pulse = expire_pulse_q;
endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer at CLK_HZ=12, SUBDIV=3, SEC_W=4: an event-count model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_game_timer;
  localparam int CLK_HZ = 12;
  localparam int SUBDIV = 3;
  localparam int SEC_W  = 4;
  localparam int STEP   = CLK_HZ / SUBDIV;
  localparam int MAXV   = (1 << SEC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b1;
  logic             pause = 1'b0;
  logic             load = 1'b0;
  logic [SEC_W-1:0] load_sec = '0;
  logic             down = 1'b0;
  logic             sub_tick, sec_tick, expired, expire_pulse;
  logic [SEC_W-1:0] seconds;

  int n_checks = 0;
  int n_pass   = 0;

  game_timer #(.CLK_HZ(CLK_HZ), .SUBDIV(SUBDIV), .SEC_W(SEC_W)) dut (
    .clk(clk), .rst(rst), .run(run), .pause(pause), .load(load),
    .load_sec(load_sec), .down(down), .sub_tick(sub_tick), .sec_tick(sec_tick),
    .seconds(seconds), .expired(expired), .expire_pulse(expire_pulse)
  );

  always #5 clk = ~clk;

  // Model: count enabled edges since the last prescaler clear; ticks fall on
  // multiples of STEP and CLK_HZ, seconds move with modular arithmetic.
  int m_edges, m_sec;
  bit m_exp, m_sub, m_stk, m_ep;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0; m_sec = 0; m_exp = 0; m_sub = 0; m_stk = 0; m_ep = 0;
    end else begin
      m_sub = 0; m_stk = 0; m_ep = 0;
      if (load) begin
        m_sec = int'(load_sec); m_edges = 0; m_exp = 0;
      end else if (!run) begin
        m_edges = 0;
      end else if (!pause && !m_exp) begin
        m_edges = m_edges + 1;
        m_sub   = (m_edges % STEP == 0);
        m_stk   = (m_edges % CLK_HZ == 0);
        if (m_stk) begin
          m_sec = down ? (m_sec + MAXV) % (MAXV + 1) : (m_sec + 1) % (MAXV + 1);
          if (m_sec == (down ? 0 : MAXV)) begin
            m_exp = 1; m_ep = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("model_sub_tick", int'(sub_tick), int'(m_sub));
    chk("model_sec_tick", int'(sec_tick), int'(m_stk));
    chk("model_seconds", int'(seconds), m_sec);
    chk("model_expired", int'(expired), int'(m_exp));
    chk("model_expire_pulse", int'(expire_pulse), int'(m_ep));
  end

  // Advance n clock edges; inputs change 2 time units after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int v, input bit dn);
    load = 1'b1; load_sec = SEC_W'(v); down = dn;
    tick(1);
    load = 1'b0;
  endtask

  int any_tick;

  initial begin
    // Reset with run=1, up mode.
    tick(3);
    chk("rst_sub_tick", int'(sub_tick), 0);
    chk("rst_seconds", int'(seconds), 0);
    chk("rst_expired", int'(expired), 0);
    rst = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick(1);
      chk("s1_sub_tick", int'(sub_tick), (e == 4 || e == 8 || e == 12 || e == 16 || e == 20 || e == 24) ? 1 : 0);
      chk("s1_sec_tick", int'(sec_tick), (e == 12 || e == 24) ? 1 : 0);
      if (e == 12) chk("s1_seconds_12", int'(seconds), 1);
    end
    chk("s1_seconds_24", int'(seconds), 2);

    // Pause of 5 cycles after edge 6 delays later ticks by 5.
    do_load(0, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      pause = (c >= 7 && c <= 11);
      tick(1);
      if (c == 8)  chk("s2_no_sub_at_8", int'(sub_tick), 0);
      if (c == 13) chk("s2_sub_at_13", int'(sub_tick), 1);
    end
    pause = 1'b0;
    chk("s2_sec_tick_17", int'(sec_tick), 1);
    chk("s2_seconds_17", int'(seconds), 1);

    // Down from 3 to expiry, then frozen.
    do_load(3, 1'b1);
    chk("s3_loaded", int'(seconds), 3);
    tick(12); chk("s3_sec_12", int'(seconds), 2);
    tick(12); chk("s3_sec_24", int'(seconds), 1);
    tick(12); chk("s3_sec_36", int'(seconds), 0);
    chk("s3_expired", int'(expired), 1);
    chk("s3_expire_pulse", int'(expire_pulse), 1);
    tick(1);
    chk("s3_pulse_once", int'(expire_pulse), 0);
    any_tick = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (sub_tick || sec_tick) any_tick++;
    end
    chk("s3_no_ticks_expired", any_tick, 0);
    chk("s3_hold_0", int'(seconds), 0);
    do_load(2, 1'b1);
    chk("s3_reload_clears", int'(expired), 0);
    tick(12); chk("s3_resume", int'(seconds), 1);

    // Up mode from 14 expires at MAX.
    do_load(14, 1'b0);
    tick(12);
    chk("s4_seconds_max", int'(seconds), 15);
    chk("s4_expired", int'(expired), 1);
    chk("s4_pulse", int'(expire_pulse), 1);
    tick(1);  chk("s4_pulse_once", int'(expire_pulse), 0);
    tick(20); chk("s4_hold", int'(seconds), 15);

    // Load at the limit wraps instead of expiring.
    do_load(0, 1'b1);
    tick(12);
    chk("s5_wrap_down", int'(seconds), 15);
    chk("s5_no_expire", int'(expired), 0);

    // Load on the wrap cycle wins over sec_tick.
    do_load(0, 1'b0);
    tick(11);
    load = 1'b1; load_sec = 4'd7;
    tick(1);
    load = 1'b0;
    chk("s6_no_sec_tick", int'(sec_tick), 0);
    chk("s6_seconds_7", int'(seconds), 7);
    tick(11); chk("s6_no_early_tick", int'(sec_tick), 0);
    tick(1);
    chk("s6_sec_tick", int'(sec_tick), 1);
    chk("s6_seconds_8", int'(seconds), 8);

    // Drop run at pre=9 for 3 cycles.
    tick(9);
    run = 1'b0;
    tick(3);
    chk("s7_held", int'(seconds), 8);
    run = 1'b1;
    tick(11); chk("s7_no_early_tick", int'(sec_tick), 0);
    tick(1);
    chk("s7_sec_tick", int'(sec_tick), 1);
    chk("s7_seconds_9", int'(seconds), 9);

    // Asynchronous reset mid-second.
    tick(5);
    rst = 1'b1;
    #1;
    chk("s8_async_seconds", int'(seconds), 0);
    chk("s8_async_expired", int'(expired), 0);
    tick(2);
    rst = 1'b0;
    tick(12);
    chk("s8_restart", int'(seconds), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
